// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator slice.
//   PWM_R_DEFAULT : default duty-counter resolution (one period = 2^R ticks)
//   DVSR_W        : prescaler divisor / counter width
//   dvsr_t        : prescaler divisor type
package pwm_pkg;

  localparam int PWM_R_DEFAULT = 16;
  localparam int DVSR_W        = 32;

  typedef logic [DVSR_W-1:0] dvsr_t;

endpackage : pwm_pkg

// File: rtl/pwm_prescaler.sv
// Programmable clock prescaler for the PWM generator.
// A free-running counter emits a one-clock tick every dvsr+1 clocks.
// Ports:
//   clk   in   system clock, rising edge
//   reset in   synchronous, active-high reset
//   dvsr  in   divisor; tick period = dvsr+1 clocks (0 = tick every clock)
//   tick  out  one-clock strobe, combinational from the counter state
module pwm_prescaler
  import pwm_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  dvsr_t dvsr,
  output logic  tick
);

  dvsr_t q_reg;
  logic  at_limit;

  // Greater-or-equal rather than equality: if dvsr is lowered below the
  // current count, the counter restarts at once instead of running to 2^32.
  assign at_limit = (q_reg >= dvsr);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (at_limit) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_reg + 1'b1;
    end
  end

  // Tick is suppressed during reset so downstream counters see a clean start.
  assign tick = at_limit & ~reset;

endmodule : pwm_prescaler

// File: rtl/pwm_generator.sv
// Fixed-resolution PWM generator.
// A prescaled R-bit duty counter sweeps 0..2^R-1; the registered output is
// high while the counter is below the effective duty word.
// PWM frequency = f_clk / ((dvsr+1) * 2^R).
// Optional feature, macro PWM_DUTY_LATCH_EN:
//   defined   - duty is captured at each period start (and on reset release),
//               so mid-period duty changes apply from the next period.
//   undefined - duty is used live and may reshape the current period.
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   duty    in   R+1-bit duty word; 0 = 0%, >= 2^R = 100%
//   dvsr    in   prescaler divisor; tick period = dvsr+1 clocks
//   pwm_out out  registered PWM output
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int R = PWM_R_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [R:0] duty,
  input  dvsr_t      dvsr,
  output logic       pwm_out
);

  logic         tick;
  logic [R-1:0] d_reg;
  logic [R:0]   duty_eff;

  pwm_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .dvsr  (dvsr),
    .tick  (tick)
  );

  // Duty counter; its natural wrap 2^R-1 -> 0 marks the period boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_reg <= '0;
    end else if (tick) begin
      d_reg <= d_reg + 1'b1;
    end
  end

`ifdef PWM_DUTY_LATCH_EN
  logic [R:0] duty_reg;
  logic       restart;
  logic       wrap;

  assign wrap = tick && (d_reg == '1);

  // restart marks the first clock after reset release. On that clock the
  // live duty is both compared and captured, so the first period is already
  // correct while duty_reg still holds its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_reg <= '0;
      restart  <= 1'b1;
    end else begin
      restart <= 1'b0;
      if (restart || wrap) begin
        duty_reg <= duty;
      end
    end
  end

  assign duty_eff = restart ? duty : duty_reg;
`else
  assign duty_eff = duty;
`endif

  // Zero-extended compare: duty_eff = 2^R or above is always greater than
  // any counter value, giving a steady high with no inter-period glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= ({1'b0, d_reg} < duty_eff);
    end
  end

endmodule : pwm_generator

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator, run at R=8 to keep periods short.
// Table-driven period/duty measurements plus directed sequences for the
// constant-level, mid-period reset and duty-change corner cases.
module tb_pwm_generator;
  import pwm_pkg::*;

  localparam int R    = 8;
  localparam int FULL = 1 << R;

  logic       clk = 1'b0;
  logic       reset;
  logic [R:0] duty;
  dvsr_t      dvsr;
  logic       pwm_out;

  int vec_count  = 0;
  int miscompares = 0;

  pwm_generator #(.R(R)) dut (
    .clk     (clk),
    .reset   (reset),
    .duty    (duty),
    .dvsr    (dvsr),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int dvsr;
    int exp_high;
    int exp_low;
    int periods;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input int actual, input int expected);
    vec_count++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Holds reset for 3 clocks with the given settings, checks the reset
  // output, releases, and returns at the first sample after release.
  task automatic apply_reset(input int d, input int v);
    @(negedge clk);
    reset = 1'b1;
    duty  = (R+1)'(d);
    dvsr  = dvsr_t'(v);
    repeat (3) @(negedge clk);
    check("reset_out", int'(pwm_out), 0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Counts consecutive samples at the given level, bounded by limit.
  task automatic measure_run(input logic level, input int limit, output int n);
    n = 0;
    while (pwm_out === level && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_high(input int samples, output int highs);
    highs = 0;
    for (int k = 0; k < samples; k++) begin
      if (pwm_out === 1'b1) highs++;
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int highs;
    int exp_h1;
    int exp_l1;

    // duty, dvsr, high clocks, low clocks, periods measured
    vecs[0] = '{64,  18, 64 * 19,  192 * 19, 3};  // 25 %
    vecs[1] = '{128, 18, 128 * 19, 128 * 19, 2};  // 50 %
    vecs[2] = '{192, 3,  192 * 4,  64 * 4,   3};  // 75 %

    reset = 1'b1;
    duty  = '0;
    dvsr  = '0;

    for (int i = 0; i < 3; i++) begin
      int limit;
      limit = FULL * (vecs[i].dvsr + 1) + 10;
      apply_reset(vecs[i].duty, vecs[i].dvsr);
      for (int p = 0; p < vecs[i].periods; p++) begin
        measure_run(1'b1, limit, n);
        check($sformatf("v%0d_p%0d_high", i, p), n, vecs[i].exp_high);
        measure_run(1'b0, limit, n);
        check($sformatf("v%0d_p%0d_low", i, p), n, vecs[i].exp_low);
      end
    end

    // duty = 0: output never rises.
    apply_reset(0, 0);
    count_high(3 * FULL, highs);
    check("duty0_highs", highs, 0);

    // duty = 2^R: high from the first clock after release, never low.
    apply_reset(FULL, 0);
    count_high(3 * FULL, highs);
    check("duty_full_highs", highs, 3 * FULL);

    // duty above 2^R still saturates at 100 %.
    apply_reset(FULL + 44, 0);
    count_high(3 * FULL, highs);
    check("duty_over_highs", highs, 3 * FULL);

    // Reset in the middle of the high phase.
    apply_reset(128, 0);
    repeat (50) @(negedge clk);
    check("midreset_before", int'(pwm_out), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_out", int'(pwm_out), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    measure_run(1'b1, FULL + 10, n);
    check("midreset_high", n, 128);
    measure_run(1'b0, FULL + 10, n);
    check("midreset_low", n, 128);

    // Duty raised from 25 % to 75 % about 20 counts into the period.
`ifdef PWM_DUTY_LATCH_EN
    exp_h1 = 64;
    exp_l1 = FULL - 64;
`else
    exp_h1 = 192;
    exp_l1 = FULL - 192;
`endif
    apply_reset(64, 0);
    count_high(20, highs);
    duty = (R+1)'(192);
    measure_run(1'b1, FULL + 10, n);
    check("dchg_p0_high", highs + n, exp_h1);
    measure_run(1'b0, FULL + 10, n);
    check("dchg_p0_low", n, exp_l1);
    measure_run(1'b1, FULL + 10, n);
    check("dchg_p1_high", n, 192);
    measure_run(1'b0, FULL + 10, n);
    check("dchg_p1_low", n, FULL - 192);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule : tb_pwm_generator
